// File: rtl/s2_kes_sched_if.sv
// rtl/s2_kes_sched_if.sv - syndrome, solver and result signal bundle for the stage-2 KES scheduler
interface s2_kes_sched_if #(
  parameter int TAG_W = 4
);
  logic             syn_valid;
  logic             syn_ready;
  logic [7:0]       syn0, syn1, syn2, syn3;
  logic [TAG_W-1:0] syn_tag;

  logic             kes_ena;
  logic [7:0]       kes_syn0, kes_syn1, kes_syn2, kes_syn3;
  logic [7:0]       kes_lambda0, kes_lambda1, kes_lambda2;
  logic [7:0]       kes_omega0, kes_omega1;
  logic             kes_done;

  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_lambda0, out_lambda1, out_lambda2;
  logic [7:0]       out_omega0, out_omega1;
  logic [TAG_W-1:0] out_tag;
  logic             out_bypass;
  logic             out_timeout;

  modport slave (
    input  syn_valid, syn0, syn1, syn2, syn3, syn_tag,
    input  kes_lambda0, kes_lambda1, kes_lambda2, kes_omega0, kes_omega1, kes_done,
    input  out_ready,
    output syn_ready,
    output kes_ena, kes_syn0, kes_syn1, kes_syn2, kes_syn3,
    output out_valid, out_lambda0, out_lambda1, out_lambda2, out_omega0, out_omega1,
    output out_tag, out_bypass, out_timeout
  );

  modport master (
    output syn_valid, syn0, syn1, syn2, syn3, syn_tag,
    output kes_lambda0, kes_lambda1, kes_lambda2, kes_omega0, kes_omega1, kes_done,
    output out_ready,
    input  syn_ready,
    input  kes_ena, kes_syn0, kes_syn1, kes_syn2, kes_syn3,
    input  out_valid, out_lambda0, out_lambda1, out_lambda2, out_omega0, out_omega1,
    input  out_tag, out_bypass, out_timeout
  );
endinterface

// File: rtl/s2_kes_sched.sv
// rtl/s2_kes_sched.sv - job scheduler in front of the stage-2 key-equation solver
// Queues syndrome sets, bypasses error-free codewords, runs the solver under a watchdog.
module s2_kes_sched #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TAG_W       = 4,
  parameter int KES_TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          rst,
  s2_kes_sched_if.slave bus,
  output logic          busy,
  output logic [15:0]   stat_bypass_cnt,
  output logic [7:0]    stat_timeout_cnt
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int WD_W = $clog2(KES_TIMEOUT);
  localparam int EW   = 32 + TAG_W;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;
  state_t state, state_nxt;

  logic [EW-1:0]    fifo_mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, empty, push, pop;
  logic [EW-1:0]    head;
  logic             head_zero, out_free;
  logic             ld_bypass, ld_job, ld_done, ld_tmo;
  logic [WD_W-1:0]  wd_cnt;
  logic [TAG_W-1:0] job_tag;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty         = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bus.syn_ready = !full;
  assign push          = bus.syn_valid && !full;
  assign head          = fifo_mem[rd_ptr[AW-1:0]];
  assign head_zero     = (head[31:0] == 32'h0);
  assign out_free      = !bus.out_valid || bus.out_ready;
  assign bus.kes_ena   = (state == S_LAUNCH);
  assign busy          = !empty || (state != S_IDLE) || bus.out_valid;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {bus.syn_tag, bus.syn3, bus.syn2, bus.syn1, bus.syn0};
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    ld_bypass = 1'b0;
    ld_job    = 1'b0;
    ld_done   = 1'b0;
    ld_tmo    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && out_free) begin
          pop = 1'b1;
          if (head_zero) begin
            ld_bypass = 1'b1;
          end else begin
            ld_job    = 1'b1;
            state_nxt = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT: begin
        // A completion in the final watchdog cycle still counts as a result.
        if (bus.kes_done) begin
          ld_done   = 1'b1;
          state_nxt = S_IDLE;
        end else if (wd_cnt == WD_W'(KES_TIMEOUT - 1)) begin
          ld_tmo    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      wd_cnt           <= '0;
      job_tag          <= '0;
      bus.kes_syn0     <= '0;
      bus.kes_syn1     <= '0;
      bus.kes_syn2     <= '0;
      bus.kes_syn3     <= '0;
      bus.out_valid    <= 1'b0;
      bus.out_lambda0  <= '0;
      bus.out_lambda1  <= '0;
      bus.out_lambda2  <= '0;
      bus.out_omega0   <= '0;
      bus.out_omega1   <= '0;
      bus.out_tag      <= '0;
      bus.out_bypass   <= 1'b0;
      bus.out_timeout  <= 1'b0;
      stat_bypass_cnt  <= '0;
      stat_timeout_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);

      if (state == S_LAUNCH)    wd_cnt <= '0;
      else if (state == S_WAIT) wd_cnt <= wd_cnt + WD_W'(1);

      if (ld_job) begin
        bus.kes_syn0 <= head[7:0];
        bus.kes_syn1 <= head[15:8];
        bus.kes_syn2 <= head[23:16];
        bus.kes_syn3 <= head[31:24];
        job_tag      <= head[EW-1:32];
      end

      if (ld_bypass) begin
        bus.out_valid   <= 1'b1;
        bus.out_lambda0 <= 8'h01;
        bus.out_lambda1 <= 8'h00;
        bus.out_lambda2 <= 8'h00;
        bus.out_omega0  <= 8'h00;
        bus.out_omega1  <= 8'h00;
        bus.out_tag     <= head[EW-1:32];
        bus.out_bypass  <= 1'b1;
        bus.out_timeout <= 1'b0;
      end else if (ld_done || ld_tmo) begin
        bus.out_valid   <= 1'b1;
        bus.out_lambda0 <= ld_done ? bus.kes_lambda0 : 8'h00;
        bus.out_lambda1 <= ld_done ? bus.kes_lambda1 : 8'h00;
        bus.out_lambda2 <= ld_done ? bus.kes_lambda2 : 8'h00;
        bus.out_omega0  <= ld_done ? bus.kes_omega0  : 8'h00;
        bus.out_omega1  <= ld_done ? bus.kes_omega1  : 8'h00;
        bus.out_tag     <= job_tag;
        bus.out_bypass  <= 1'b0;
        bus.out_timeout <= ld_tmo;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      if (ld_bypass && (stat_bypass_cnt != 16'hFFFF)) stat_bypass_cnt <= stat_bypass_cnt + 16'd1;
      if (ld_tmo && (stat_timeout_cnt != 8'hFF))      stat_timeout_cnt <= stat_timeout_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_s2_kes_sched.sv
// tb/tb_s2_kes_sched.sv - scoreboard bench for s2_kes_sched with a behavioural solver model
module tb_s2_kes_sched;
  localparam int KT = 8;

  typedef struct packed {
    logic [3:0]  tag;
    logic        byp;
    logic        tmo;
    logic [39:0] res;
  } exp_t;

  typedef struct packed {
    logic [31:0] syn;
    int          delay;
    logic [39:0] res;
  } plan_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [15:0] stat_bypass_cnt;
  logic [7:0]  stat_timeout_cnt;

  s2_kes_sched_if #(.TAG_W(4)) bus ();

  s2_kes_sched #(.FIFO_DEPTH(4), .TAG_W(4), .KES_TIMEOUT(KT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy),
    .stat_bypass_cnt(stat_bypass_cnt), .stat_timeout_cnt(stat_timeout_cnt)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    n_vec = 0, n_err = 0;
  int    rst_epoch = 0, ena_cnt = 0, ena_base = 0, exp_launch = 0;
  logic [15:0] exp_byp = 0;
  logic [7:0]  exp_to = 0;
  bit    rand_mode = 0;
  logic  ready_val = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: zero syndromes bypass; otherwise the solver plan decides result or timeout.
  function automatic void model_push(input logic [31:0] s, input logic [3:0] tag,
                                     input int delay, input logic [39:0] res);
    exp_t  e;
    plan_t p;
    e.tag = tag;
    if (s == 32'h0) begin
      e.byp = 1'b1; e.tmo = 1'b0; e.res = 40'h01_00_00_00_00;
      if (exp_byp != 16'hFFFF) exp_byp++;
    end else begin
      exp_launch++;
      p.syn = s; p.delay = delay; p.res = res;
      plan_q.push_back(p);
      e.byp = 1'b0;
      if (delay == 0) begin
        e.tmo = 1'b1; e.res = '0;
        if (exp_to != 8'hFF) exp_to++;
      end else begin
        e.tmo = 1'b0; e.res = res;
      end
    end
    exp_q.push_back(e);
  endfunction

  task automatic push_job(input logic [31:0] s, input logic [3:0] tag, input int delay,
                          input logic [39:0] res, input int max_cyc, output bit ok);
    bus.syn_valid = 1'b1;
    {bus.syn3, bus.syn2, bus.syn1, bus.syn0} = s;
    bus.syn_tag = tag;
    ok = 0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (bus.syn_ready) begin
        ok = 1;
        model_push(s, tag, delay, res);
      end
      @(posedge clk);
      #1;
    end
    bus.syn_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rst_epoch++;
    exp_q.delete();
    plan_q.delete();
    exp_byp = 0; exp_to = 0; exp_launch = 0;
    idle(2);
    rst = 1'b0;
    ena_base = ena_cnt;
  endtask

  task automatic check_reset_state(input string name);
    check({name, " ctrl"}, 64'({bus.out_valid, bus.kes_ena, bus.out_bypass, bus.out_timeout,
                                bus.out_tag, busy, bus.syn_ready}), 64'b0000_0000_0_1);
    check({name, " out_data"}, {24'h0, bus.out_lambda0, bus.out_lambda1, bus.out_lambda2,
                                bus.out_omega0, bus.out_omega1}, 64'h0);
    check({name, " kes_syn"}, 64'({bus.kes_syn3, bus.kes_syn2, bus.kes_syn1, bus.kes_syn0}), 64'h0);
    check({name, " stats"}, 64'({stat_bypass_cnt, stat_timeout_cnt}), 64'h0);
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || busy) && i < 3000) begin
      idle(1);
      i++;
    end
    check({name, " drained"}, 64'({(exp_q.size() == 0), busy}), 64'b10);
    check({name, " stat_bypass"}, 64'(stat_bypass_cnt), 64'(exp_byp));
    check({name, " stat_timeout"}, 64'(stat_timeout_cnt), 64'(exp_to));
    check({name, " kes_ena count"}, 64'(ena_cnt - ena_base), 64'(exp_launch));
  endtask

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_mode ? 1'($urandom) : ready_val;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.kes_ena) ena_cnt++;
    end
  end

  // Monitor: every accepted output must be the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious out_valid", 64'(bus.out_valid), 64'h0);
        end else begin
          e = exp_q.pop_front();
          check("result", 64'({bus.out_tag, bus.out_bypass, bus.out_timeout, bus.out_lambda0,
                               bus.out_lambda1, bus.out_lambda2, bus.out_omega0, bus.out_omega1}),
                64'(e));
        end
      end
    end
  end

  // Solver model: answers each launch after the planned delay, or never for delay 0.
  initial begin
    plan_t p;
    int    ep;
    bus.kes_done = 1'b0;
    {bus.kes_lambda0, bus.kes_lambda1, bus.kes_lambda2, bus.kes_omega0, bus.kes_omega1} = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.kes_ena) begin
        ep = rst_epoch;
        if (plan_q.size() == 0) begin
          check("unplanned kes_ena", 64'(bus.kes_ena), 64'h0);
        end else begin
          p = plan_q.pop_front();
          check("kes_syn at launch", 64'({bus.kes_syn3, bus.kes_syn2, bus.kes_syn1, bus.kes_syn0}), 64'(p.syn));
          if (p.delay == 0) begin
            repeat (KT) @(posedge clk);
            #1;
            if (ep == rst_epoch) check("timeout too early", 64'(bus.out_valid), 64'h0);
            @(posedge clk);
            #1;
            if (ep == rst_epoch) check("timeout latency", 64'({bus.out_valid, bus.out_timeout}), 64'b11);
          end else begin
            repeat (p.delay) @(posedge clk);
            #1;
            if (ep == rst_epoch)
              check("kes_syn held", 64'({bus.kes_syn3, bus.kes_syn2, bus.kes_syn1, bus.kes_syn0}), 64'(p.syn));
            bus.kes_done = 1'b1;
            {bus.kes_lambda0, bus.kes_lambda1, bus.kes_lambda2, bus.kes_omega0, bus.kes_omega1} = p.res;
            @(posedge clk);
            #1;
            bus.kes_done = 1'b0;
            {bus.kes_lambda0, bus.kes_lambda1, bus.kes_lambda2, bus.kes_omega0, bus.kes_omega1} = '0;
            if (ep == rst_epoch) check("done latency", 64'(bus.out_valid), 64'h1);
          end
        end
      end
    end
  end

  initial begin
    bit ok;
    logic [31:0] s;
    bus.syn_valid = 1'b0;
    {bus.syn3, bus.syn2, bus.syn1, bus.syn0} = '0;
    bus.syn_tag = '0;
    @(posedge clk);
    #1;
    do_reset();
    check_reset_state("reset");

    push_job(32'h0, 4'd3, 0, 40'h0, 20, ok);
    check("bypass pre-latency", 64'(bus.out_valid), 64'h0);
    idle(1);
    check("bypass latency", 64'(bus.out_valid), 64'h1);
    check("bypass count", 64'(stat_bypass_cnt), 64'h1);
    drain("bypass");

    push_job(32'hF0113C5A, 4'd5, 5, 40'h01_A2_37_5A_0E, 20, ok);
    drain("solver");
    check("kes_syn after job", 64'({bus.kes_syn0, bus.kes_syn1, bus.kes_syn2, bus.kes_syn3}), 64'h5A3C11F0);

    push_job(32'h00000077, 4'd6, KT, 40'h01_11_22_33_44, 20, ok);
    drain("done at timeout");

    push_job(32'h00000001, 4'd7, 0, 40'h0, 20, ok);
    push_job(32'h00000200, 4'd8, 3, 40'h01_BE_EF_12_34, 20, ok);
    drain("timeout");

    ready_val = 1'b0;
    idle(2);
    push_job(32'h0, 4'd15, 0, 40'h0, 20, ok);
    idle(2);
    for (int i = 0; i < 4; i++) begin
      push_job(32'h01020304 + 32'(i), 4'(i), 2, {8'h01, 8'(i), 24'hA5A5A5}, 20, ok);
      check("fill push accepted", 64'(ok), 64'h1);
    end
    check("full syn_ready", 64'({bus.syn_ready, busy}), 64'b01);
    push_job(32'hDEADBEEF, 4'd4, 2, 40'h0, 6, ok);
    check("fifth blocked", 64'(ok), 64'h0);
    ready_val = 1'b1;
    drain("fill");

    push_job(32'h0A0B0C0D, 4'd9, 6, 40'h01_02_03_04_05, 20, ok);
    push_job(32'h00000011, 4'd10, 2, 40'h01_00_00_00_01, 20, ok);
    push_job(32'h00000022, 4'd11, 2, 40'h01_00_00_00_02, 20, ok);
    do_reset();
    check_reset_state("mid-job reset");
    idle(12);
    check_reset_state("after stale kes_done");
    drain("post reset");

    rand_mode = 1;
    for (int n = 0; n < 300; n++) begin
      s = ($urandom_range(0, 9) < 4) ? 32'h0 : $urandom();
      push_job(s, 4'(n), $urandom_range(0, KT), {$urandom(), 8'($urandom())}, 500, ok);
      check("random push accepted", 64'(ok), 64'h1);
      idle($urandom_range(0, 2));
    end
    drain("random");
    rand_mode = 0;

    for (int n = 0; n < 260; n++) push_job(32'h00001000 + 32'(n), 4'(n), 0, 40'h0, 500, ok);
    drain("timeout saturation");
    check("timeout counter saturated", 64'(stat_timeout_cnt), 64'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
